// File: rtl/prach_fft3_out_reorder.sv
`default_nettype none
// ============================================================================
// Module      : prach_fft3_out_reorder
// Description : Output reorder buffer for the 3-point DIT FFT stage of the
//               PRACH long-sequence FFT. Frames of 3*NUM_SUB_POINTS bins
//               arrive stride-3 interleaved (n = 3*m + b). Each frame is
//               written into one bank of a ping-pong RAM at address
//               b*NUM_SUB_POINTS + m. It is then read back linearly, which
//               gives natural bin order, as one contiguous burst.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               din_dr/din_di     - input sample (real/imag)
//               din_dv            - input sample valid
//               sync_in           - first sample of an input frame
//               dout_dr/dout_di   - output sample, natural bin order
//               dout_dv           - output valid (L contiguous cycles)
//               sync_out          - first sample of an output burst
//               frame_err         - pulse: mid-frame sync, partial discarded
// Revision    : 1.0 - initial release
// ============================================================================
module prach_fft3_out_reorder #(
    parameter int NUM_SUB_POINTS = 512,
    parameter int DATA_WIDTH     = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din_dr,
    input  logic [DATA_WIDTH-1:0] din_di,
    input  logic                  din_dv,
    input  logic                  sync_in,
    output logic [DATA_WIDTH-1:0] dout_dr,
    output logic [DATA_WIDTH-1:0] dout_di,
    output logic                  dout_dv,
    output logic                  sync_out,
    output logic                  frame_err
);

    localparam int c_FRAME_LEN = 3 * NUM_SUB_POINTS;
    localparam int c_M_W       = (NUM_SUB_POINTS > 1) ? $clog2(NUM_SUB_POINTS) : 1;
    localparam int c_A_W       = $clog2(c_FRAME_LEN);
    localparam int c_I_W       = $clog2(2 * c_FRAME_LEN);

    localparam logic [1:0]       c_B_LAST = 2'd2;
    localparam logic [c_M_W-1:0] c_M_LAST = c_M_W'(NUM_SUB_POINTS - 1);
    localparam logic [c_A_W-1:0] c_A_LAST = c_A_W'(c_FRAME_LEN - 1);
    localparam logic [c_A_W-1:0] c_BASE_1 = c_A_W'(NUM_SUB_POINTS);
    localparam logic [c_A_W-1:0] c_BASE_2 = c_A_W'(2 * NUM_SUB_POINTS);
    localparam logic [c_I_W-1:0] c_BANK_1 = c_I_W'(c_FRAME_LEN);

    typedef enum logic [0:0] {WR_WAIT_SYNC = 1'b0, WR_FILL = 1'b1} wr_state_t;
    typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_READ = 1'b1} rd_state_t;

    // ------------------------------------------------------------------
    // Writer
    // ------------------------------------------------------------------
    wr_state_t        r_wr_state, w_wr_state_nxt;
    logic [1:0]       r_b;
    logic [c_M_W-1:0] r_m;
    logic             r_wr_bank;
    logic [1:0]       r_full, w_full_nxt;
    logic             r_frame_err;

    logic             w_we, w_restart, w_ferr, w_first, w_last, w_wr_done;
    logic [c_A_W-1:0] w_wa, w_base;
    logic [c_I_W-1:0] w_widx;

    assign w_first = (r_b == 2'd0) && (r_m == '0);
    assign w_last  = (r_b == c_B_LAST) && (r_m == c_M_LAST);

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_we           = 1'b0;
        w_restart      = 1'b0;
        w_ferr         = 1'b0;
        if (din_dv) begin
            case (r_wr_state)
                WR_WAIT_SYNC: begin
                    if (sync_in) begin
                        w_we           = 1'b1;
                        w_restart      = 1'b1;
                        w_wr_state_nxt = WR_FILL;
                    end
                end
                WR_FILL: begin
                    if (sync_in && !w_first) begin
                        // Abandon the partial frame; this sample becomes n=0
                        // of a new frame in the same bank.
                        w_we      = 1'b1;
                        w_restart = 1'b1;
                        w_ferr    = 1'b1;
                    end else if (!sync_in && w_first) begin
                        w_wr_state_nxt = WR_WAIT_SYNC;
                    end else begin
                        w_we = 1'b1;
                    end
                end
                default: w_wr_state_nxt = WR_WAIT_SYNC;
            endcase
        end
    end

    // b*NUM_SUB_POINTS from constants, no multiplier
    always_comb begin
        case (r_b)
            2'd0:    w_base = '0;
            2'd1:    w_base = c_BASE_1;
            default: w_base = c_BASE_2;
        endcase
    end

    assign w_wa      = w_restart ? '0 : (w_base + c_A_W'(r_m));
    assign w_widx    = r_wr_bank ? (c_BANK_1 + c_I_W'(w_wa)) : c_I_W'(w_wa);
    assign w_wr_done = w_we && !w_restart && w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state  <= WR_WAIT_SYNC;
            r_b         <= '0;
            r_m         <= '0;
            r_wr_bank   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_state  <= w_wr_state_nxt;
            r_frame_err <= w_ferr;
            if (w_we) begin
                if (w_restart) begin
                    r_b <= 2'd1;
                    r_m <= '0;
                end else if (w_last) begin
                    r_b       <= '0;
                    r_m       <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else if (r_b == c_B_LAST) begin
                    r_b <= '0;
                    r_m <= r_m + c_M_W'(1);
                end else begin
                    r_b <= r_b + 2'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Reader
    // ------------------------------------------------------------------
    rd_state_t        r_rd_state, w_rd_state_nxt;
    logic             r_rd_bank, w_rd_bank_nxt;
    logic [c_A_W-1:0] r_rd_addr, w_rd_addr_nxt;
    logic             w_ren, w_rd_done;
    logic [c_I_W-1:0] w_ridx;

    assign w_ren     = (r_rd_state == RD_READ);
    assign w_rd_done = w_ren && (r_rd_addr == c_A_LAST);
    assign w_ridx    = r_rd_bank ? (c_BANK_1 + c_I_W'(r_rd_addr)) : c_I_W'(r_rd_addr);

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_bank_nxt  = r_rd_bank;
        w_rd_addr_nxt  = r_rd_addr;
        case (r_rd_state)
            RD_IDLE: begin
                w_rd_addr_nxt = '0;
                if (r_full[r_rd_bank]) begin
                    w_rd_state_nxt = RD_READ;
                end
            end
            RD_READ: begin
                if (w_rd_done) begin
                    w_rd_addr_nxt  = '0;
                    w_rd_bank_nxt  = ~r_rd_bank;
                    // Chain straight into the other bank when it is ready
                    w_rd_state_nxt = r_full[~r_rd_bank] ? RD_READ : RD_IDLE;
                end else begin
                    w_rd_addr_nxt = r_rd_addr + c_A_W'(1);
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    // Writer and reader always address opposite banks, so set and clear
    // never collide on the same bit.
    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_done) w_full_nxt[r_rd_bank] = 1'b0;
        if (w_wr_done) w_full_nxt[r_wr_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= RD_IDLE;
            r_rd_bank  <= 1'b0;
            r_rd_addr  <= '0;
            r_full     <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_rd_bank  <= w_rd_bank_nxt;
            r_rd_addr  <= w_rd_addr_nxt;
            r_full     <= w_full_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Ping-pong RAM (no reset on storage) and output pipeline
    // ------------------------------------------------------------------
    logic [2*DATA_WIDTH-1:0] r_mem [0:2*c_FRAME_LEN-1];
    logic [2*DATA_WIDTH-1:0] r_rd_data;
    logic                    r_rd_vld, r_rd_sync;
    logic [DATA_WIDTH-1:0]   r_dout_dr, r_dout_di;
    logic                    r_dout_dv, r_sync_out;

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_widx] <= {din_dr, din_di};
        if (w_ren) r_rd_data <= r_mem[w_ridx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld   <= 1'b0;
            r_rd_sync  <= 1'b0;
            r_dout_dv  <= 1'b0;
            r_sync_out <= 1'b0;
            r_dout_dr  <= '0;
            r_dout_di  <= '0;
        end else begin
            r_rd_vld   <= w_ren;
            r_rd_sync  <= w_ren && (r_rd_addr == '0);
            r_dout_dv  <= r_rd_vld;
            r_sync_out <= r_rd_sync;
            r_dout_dr  <= r_rd_vld ? r_rd_data[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
            r_dout_di  <= r_rd_vld ? r_rd_data[DATA_WIDTH-1:0] : '0;
        end
    end

    assign dout_dr   = r_dout_dr;
    assign dout_di   = r_dout_di;
    assign dout_dv   = r_dout_dv;
    assign sync_out  = r_sync_out;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: doc/prach_fft3_out_reorder.md
Name: prach_fft3_out_reorder

Overview:
- Downstream neighbour of the 3-point DIT FFT stage in the PRACH long-sequence FFT.
- Accepts one frame of 3*NumSubPoints bins per frame in FFT output order, stride-3 interleaved.
- Reorders the frame into natural bin order using a ping-pong RAM.
- Emits each frame as a contiguous burst with a frame sync pulse.

Parameters:
NumSubPoints, 512, size of the radix-2 sub-FFT; frame length L = 3*NumSubPoints
DataWidth, 18, width of each real/imag component

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
din_dr  in  DataWidth  input real part
din_di  in  DataWidth  input imaginary part
din_dv  in  1  input sample valid
sync_in  in  1  first sample of frame; only meaningful when din_dv=1
dout_dr  out  DataWidth  output real part, natural bin order
dout_di  out  DataWidth  output imaginary part
dout_dv  out  1  output valid
sync_out  out  1  high with first output sample of each frame
frame_err  out  1  one-cycle pulse: sync_in seen mid-frame, partial frame discarded

Behaviour:
- Reset: rst sampled on clk edge. All outputs 0; both bank-full flags cleared; writer enters WAIT_SYNC; reader enters IDLE; bank selectors point to bank 0.
- Memory: two banks of L complex words (2*DataWidth each), simple dual port, 1-cycle registered read.
- Writer FSM, states WAIT_SYNC and FILL:
  - WAIT_SYNC: samples with din_dv=1 and sync_in=0 are discarded. din_dv=1 and sync_in=1 writes sample n=0 and moves to FILL.
  - Write counters: b (0..2) and m (0..NumSubPoints-1). Sample n = 3*m+b is written to address b*NumSubPoints + m in the current write bank. b increments per accepted sample; on wrap it returns to 0 and m increments. No dividers.
  - Sample n=L-1 accepted: set full flag of the write bank, toggle the write bank, return to FILL with counters zeroed, expecting the next sync.
  - Next frame's first sample: if it lacks sync_in, return to WAIT_SYNC and discard it.
  - sync_in=1 while FILL with n≠0: pulse frame_err, discard the partial frame (no full flag), restart at n=0 in the same bank with this sample.
  - Samples with din_dv=0 are ignored. Counters hold through gaps.
- Reader FSM, states IDLE and READ:
  - IDLE: when the full flag of the read bank is set, enter READ and issue read address 0.
  - READ: issue one address per cycle, 0..L-1, with no gaps. After L-1, clear that bank's full flag, toggle the read bank, then:
    - if the other bank's full flag is set, continue back-to-back with no idle cycle;
    - otherwise return to IDLE.
- Output pipeline: RAM read register, then output register.
  - dout_dv is high for exactly L consecutive cycles per frame.
  - sync_out is high only on the first of those cycles.
  - dout_dr/dout_di are 0 whenever dout_dv=0.
- Latency: the first output (sync_out=1) appears 3 clk cycles after the edge that accepted sample n=L-1.
- Overflow: none possible. The input needs ≥L cycles per frame and the reader drains L per frame, so a bank is never rewritten while being read; the writer never enters a full bank.
- Simultaneous events:
  - The writer setting a full flag and the reader clearing the other flag in the same cycle are independent.
  - The reader may start in the cycle after the flag is set.
- Reset mid-frame or mid-burst: output stops on the next cycle. The pending frame is lost and no partial burst continues.
- Arithmetic: data is passed through bit-exact, with no scaling or rounding.

Test Plan:
- NumSubPoints=4 (L=12); inputs dr=n, di=-n for n=0..11, sync_in on n=0, din_dv continuous → output dr order 0,3,6,9,1,4,7,10,2,5,8,11, di negated. sync_out with the first sample, 3 cycles after n=11 accepted. dout_dv high 12 cycles.
- Same frame with din_dv toggling 1/0 every cycle → identical output order, burst still 12 contiguous cycles.
- Two frames back-to-back (24 continuous valid samples, sync at 0 and 12; frame 2 values 100+n) → 24 contiguous dout_dv cycles. sync_out at burst offsets 0 and 12. Second burst begins 100,103,106,….
- Five samples before any sync_in, then a valid frame → the five samples never appear; the frame outputs correctly.
- sync_in asserted at n=7 of a frame, followed by a full 12-sample frame → frame_err one-cycle pulse. Only the new frame is output, 12 samples, correct order.
- rst asserted for 1 cycle in the middle of an output burst → all outputs 0 from the next cycle. No further output until a new sync-aligned frame completes.
